piso_shift_register: RTL and testbench

PISO_SHIFT_REGISTER -- requirements
Module: piso_shift_register

---
 rtl/piso_shift_register.sv | 101 ++++++++++
 tb/tb_piso_shift_register.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/piso_shift_register.sv
// rtl/piso_shift_register.sv - parallel-in serial-out shifter with optional sign extension
module piso_shift_register #(
  parameter int x   = 8,
  parameter int EXT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [x-1:0] load_data,
  input  logic         extend,
  input  logic         shift_en,
  output logic         shift_out,
  output logic         out_valid,
  output logic         last
);

  // Counter covers whichever phase is longer, so it never wraps inside a frame.
  localparam int MAXN = (x > EXT) ? x : EXT;
  localparam int CW   = (MAXN > 1) ? $clog2(MAXN) : 1;

  localparam logic [CW-1:0] DATA_LAST = CW'(x - 1);
  localparam logic [CW-1:0] EXT_LAST  = CW'(EXT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] EXTEND = 2'd2;

  logic [1:0]    state;
  logic [x-1:0]  data_q;
  logic [CW-1:0] cnt;
  logic          ext_q;
  logic          msb_q;

  // Frame sequencing: capture on load, walk data bits, then optional extension bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      data_q <= '0;
      cnt    <= '0;
      ext_q  <= 1'b0;
      msb_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            data_q <= load_data;
            ext_q  <= extend;
            msb_q  <= load_data[x-1];
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (cnt == DATA_LAST) begin
              cnt   <= '0;
              state <= ext_q ? EXTEND : IDLE;
            end else begin
              data_q <= {1'b0, data_q[x-1:1]};
              cnt    <= cnt + CW'(1);
            end
          end
        end
        EXTEND: begin
          if (shift_en) begin
            if (cnt == EXT_LAST) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decoded from state; IDLE forces the serial bit low.
  always_comb begin
    load_ready = 1'b0;
    out_valid  = 1'b0;
    shift_out  = 1'b0;
    last       = 1'b0;
    case (state)
      SHIFT: begin
        out_valid = 1'b1;
        shift_out = data_q[0];
        last      = (cnt == DATA_LAST) && !ext_q;
      end
      EXTEND: begin
        out_valid = 1'b1;
        shift_out = msb_q;
        last      = (cnt == EXT_LAST);
      end
      default: load_ready = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_piso_shift_register.sv
// tb/tb_piso_shift_register.sv - testbench for piso_shift_register
module tb_piso_shift_register;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [7:0] load_data = 8'h00;
  logic       extend = 1'b0;
  logic       shift_en = 1'b0;
  logic       shift_out;
  logic       out_valid;
  logic       last;

  int checks = 0;
  int errors = 0;

  piso_shift_register #(.x(8), .EXT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .extend    (extend),
    .shift_en  (shift_en),
    .shift_out (shift_out),
    .out_valid (out_valid),
    .last      (last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is just the queue of bits still to be presented.
  bit mq[$];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
    end else if (mq.size() == 0) begin
      if (load_valid) begin
        for (int i = 0; i < 8; i++) mq.push_back(load_data[i]);
        if (extend) for (int i = 0; i < 4; i++) mq.push_back(load_data[7]);
      end
    end else if (shift_en) begin
      void'(mq.pop_front());
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("out_valid", {31'b0, out_valid},  {31'b0, mq.size() != 0});
    check("load_ready", {31'b0, load_ready}, {31'b0, mq.size() == 0});
    check("shift_out", {31'b0, shift_out},  {31'b0, (mq.size() != 0) ? mq[0] : 1'b0});
    check("last", {31'b0, last}, {31'b0, mq.size() == 1});
  end

  // Serial-in receiver in loopback, LSB first.
  logic [7:0] sipo_q;
  always @(posedge clk or negedge rst) begin
    if (!rst) sipo_q <= 8'h00;
    else if (out_valid && shift_en) sipo_q <= {shift_out, sipo_q[7:1]};
  end

  // Loads one word then gathers the frame; optional stall and busy re-offer.
  task automatic run_frame(input logic [7:0] d, input bit ext, input int stall_at,
                           input int stall_len, input bit busy,
                           output logic [15:0] bits, output int nbits,
                           output int ncycles, output int last_idx);
    int stalled = 0;
    int budget = 0;
    bits = '0; nbits = 0; ncycles = 0; last_idx = -1;
    load_valid = 1'b1; load_data = d; extend = ext; shift_en = 1'b1;
    @(posedge clk); #1;
    if (busy) begin
      load_data = 8'hFF; extend = 1'b0;
    end else begin
      load_valid = 1'b0;
      load_data = 8'($urandom); extend = 1'($urandom);
    end
    while (out_valid && budget < 100) begin
      budget++;
      ncycles++;
      if (nbits == stall_at && stalled < stall_len) begin
        shift_en = 1'b0;
        stalled++;
      end else begin
        shift_en = 1'b1;
      end
      if (shift_en) begin
        bits[nbits] = shift_out;
        if (last) last_idx = nbits;
        nbits++;
      end
      @(posedge clk); #1;
    end
    check("frame_timeout", {31'b0, budget >= 100}, 32'd0);
    check("ready_after_frame", {31'b0, load_ready}, 32'd1);
  endtask

  logic [15:0] bits;
  int nbits, ncyc, lidx;

  initial begin
    #3;
    check("rst_ready", {31'b0, load_ready}, 32'd1);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_shift_out", {31'b0, shift_out}, 32'd0);
    check("rst_last", {31'b0, last}, 32'd0);
    #20;
    rst = 1'b1;
    shift_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Basic 8'hCA frame, then loopback receiver contents.
    run_frame(8'hCA, 1'b0, -1, 0, 1'b0, bits, nbits, ncyc, lidx);
    check("basic_bits", {16'b0, bits}, 32'h00CA);
    check("basic_nbits", nbits, 8);
    check("basic_last_idx", lidx, 7);
    check("loopback_q", {24'b0, sipo_q}, 32'h00CA);

    // Extension with MSB=1 and MSB=0.
    run_frame(8'hCA, 1'b1, -1, 0, 1'b0, bits, nbits, ncyc, lidx);
    check("ext1_bits", {16'b0, bits}, 32'h0FCA);
    check("ext1_nbits", nbits, 12);
    check("ext1_last_idx", lidx, 11);
    run_frame(8'h4A, 1'b1, -1, 0, 1'b0, bits, nbits, ncyc, lidx);
    check("ext0_bits", {16'b0, bits}, 32'h004A);
    check("ext0_nbits", nbits, 12);

    // Stall 3 cycles while bit 2 is presented.
    run_frame(8'hCA, 1'b0, 2, 3, 1'b0, bits, nbits, ncyc, lidx);
    check("stall_bits", {16'b0, bits}, 32'h00CA);
    check("stall_cycles", ncyc, 11);

    // Busy offer of 8'hFF is ignored until the IDLE cycle, then taken.
    run_frame(8'hCA, 1'b0, -1, 0, 1'b1, bits, nbits, ncyc, lidx);
    check("busy_bits", {16'b0, bits}, 32'h00CA);
    run_frame(8'hFF, 1'b0, -1, 0, 1'b0, bits, nbits, ncyc, lidx);
    check("busy_ff_bits", {16'b0, bits}, 32'h00FF);
    check("busy_ff_nbits", nbits, 8);

    // Asynchronous reset mid-frame after bit 4 is on the line.
    load_valid = 1'b1; load_data = 8'hCA; extend = 1'b0; shift_en = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("pre_rst_bit4", {31'b0, shift_out}, 32'd0);
    check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_ready", {31'b0, load_ready}, 32'd1);
    check("async_valid", {31'b0, out_valid}, 32'd0);
    check("async_shift_out", {31'b0, shift_out}, 32'd0);
    check("async_last", {31'b0, last}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", {31'b0, out_valid}, 32'd0);
    run_frame(8'h35, 1'b0, -1, 0, 1'b0, bits, nbits, ncyc, lidx);
    check("after_rst_bits", {16'b0, bits}, 32'h0035);
    check("after_rst_bit0", {31'b0, bits[0]}, 32'd1);

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
